m_lsu: RTL and testbench

- Memory-stage load/store unit. Sits directly downstream of the execute-stage ALU and consumes its result as the effective address, plus its load/store overflow flag.
- Checks address alignment and overflow, and raises AdEL/AdES.
- Drives a request/grant/rvalid data-bus handshake with byte enables and lane-replicated store data.
- Returns sign/zero-extended load data, and stalls the pipeline while an access is outstanding.

---
 rtl/m_lsu.sv | 246 ++++++++++++++++++++++++
 tb/tb_m_lsu.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_lsu.sv
// ---------------------------------------------------------------------------
// m_lsu -- memory-stage load/store unit.
//
// Takes the execute-stage ALU result as the effective address, checks it
// for alignment and overflow (raising AdEL/AdES), and otherwise runs one
// access on a request/grant/rvalid data bus. Load data comes back sign- or
// zero-extended. The pipeline is stalled while an access is outstanding.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   valid_in   M stage holds a live instruction
//   mem_op     0 NONE, 1 LW, 2 LH, 3 LHU, 4 LB, 5 LBU, 6 SW, 7 SH, 8 SB,
//              9-15 NONE
//   addr       effective address
//   ov_dm      address-calculation overflow
//   wdata      store source register value
//   req_o      bus request (registered)
//   we_o       bus write enable (registered)
//   addr_o     word-aligned bus address (registered)
//   be_o       byte enables (registered)
//   wdata_o    lane-replicated store data (registered)
//   gnt_i      bus grant, sampled only while requesting
//   rvalid_i   read data valid, sampled only while waiting for a load
//   rdata_i    raw read word
//   stall      freeze stages F through M
//   done       one-cycle completion pulse
//   rdata_o    extended load result (registered), valid with done
//   exc_valid  address exception this cycle
//   exc_code   EXC_ADEL / EXC_ADES when exc_valid, else 0
// ---------------------------------------------------------------------------
module m_lsu #(
  parameter logic [4:0] EXC_ADEL = 5'd4,
  parameter logic [4:0] EXC_ADES = 5'd5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [3:0]  mem_op,
  input  logic [31:0] addr,
  input  logic        ov_dm,
  input  logic [31:0] wdata,
  output logic        req_o,
  output logic        we_o,
  output logic [31:0] addr_o,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  input  logic        gnt_i,
  input  logic        rvalid_i,
  input  logic [31:0] rdata_i,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata_o,
  output logic        exc_valid,
  output logic [4:0]  exc_code
);

  localparam logic [3:0] OP_LW  = 4'd1;
  localparam logic [3:0] OP_LH  = 4'd2;
  localparam logic [3:0] OP_LHU = 4'd3;
  localparam logic [3:0] OP_LB  = 4'd4;
  localparam logic [3:0] OP_LBU = 4'd5;
  localparam logic [3:0] OP_SW  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SB  = 4'd8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        is_load;
  logic        is_store;
  logic        access;
  logic        misalign;
  logic        fault;
  logic        accept;
  logic [3:0]  be_calc;
  logic [31:0] wdata_calc;

  logic [3:0]  op_q;
  logic [1:0]  lane_q;

  // Select the addressed byte/halfword of the raw bus word and extend it.
  function automatic logic [31:0] load_ext(input logic [3:0]  op,
                                           input logic [1:0]  lane,
                                           input logic [31:0] raw);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = raw[7:0];
      2'd1:    b = raw[15:8];
      2'd2:    b = raw[23:16];
      default: b = raw[31:24];
    endcase
    h = lane[1] ? raw[31:16] : raw[15:0];
    case (op)
      OP_LH:   load_ext = {{16{h[15]}}, h};
      OP_LHU:  load_ext = {16'h0000, h};
      OP_LB:   load_ext = {{24{b[7]}}, b};
      OP_LBU:  load_ext = {24'h000000, b};
      default: load_ext = raw;
    endcase
  endfunction

  // -------------------------------------------------------------------------
  // Request decode: classification, fault detection, lane enables, data.
  // -------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default on entry so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misalign   = 1'b0;
    be_calc    = 4'b0000;
    wdata_calc = 32'h0000_0000;
    case (mem_op)
      OP_LW: begin
        is_load  = 1'b1;
        misalign = |addr[1:0];
        be_calc  = 4'b1111;
      end
      OP_LH, OP_LHU: begin
        is_load  = 1'b1;
        misalign = addr[0];
        be_calc  = addr[1] ? 4'b1100 : 4'b0011;
      end
      OP_LB, OP_LBU: begin
        is_load  = 1'b1;
        be_calc  = 4'b0001 << addr[1:0];
      end
      OP_SW: begin
        is_store   = 1'b1;
        misalign   = |addr[1:0];
        be_calc    = 4'b1111;
        wdata_calc = wdata;
      end
      OP_SH: begin
        is_store   = 1'b1;
        misalign   = addr[0];
        be_calc    = addr[1] ? 4'b1100 : 4'b0011;
        wdata_calc = {2{wdata[15:0]}};
      end
      OP_SB: begin
        is_store   = 1'b1;
        be_calc    = 4'b0001 << addr[1:0];
        wdata_calc = {4{wdata[7:0]}};
      end
      default: ;
    endcase
  end

  // Qualifying with reset keeps the combinational outputs at zero while
  // reset is held, regardless of what the upstream stage presents.
  assign access = reset && valid_in && (is_load || is_store);
  assign fault  = access && (ov_dm || misalign) && (state == S_IDLE);
  assign accept = access && !(ov_dm || misalign) && (state == S_IDLE);

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (accept)   state_next = S_REQ;
      S_REQ:  if (gnt_i)    state_next = we_o ? S_DONE : S_WAIT;
      S_WAIT: if (rvalid_i) state_next = S_DONE;
      S_DONE:               state_next = S_IDLE;
      default:              state_next = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: combinational outputs
  // -------------------------------------------------------------------------
  always_comb begin
    stall     = 1'b0;
    done      = 1'b0;
    exc_valid = 1'b0;
    exc_code  = 5'd0;
    case (state)
      S_IDLE: begin
        if (fault) begin
          exc_valid = 1'b1;
          exc_code  = is_store ? EXC_ADES : EXC_ADEL;
        end
        stall = accept;
      end
      S_REQ, S_WAIT: stall = 1'b1;
      // The instruction is still in M this cycle; releasing the stall lets
      // the pipeline advance at the end of it.
      S_DONE:        done  = 1'b1;
      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Registered bus fields and load result
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_o   <= 1'b0;
      we_o    <= 1'b0;
      addr_o  <= 32'h0000_0000;
      be_o    <= 4'b0000;
      wdata_o <= 32'h0000_0000;
      rdata_o <= 32'h0000_0000;
      op_q    <= 4'd0;
      lane_q  <= 2'd0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            req_o   <= 1'b1;
            we_o    <= is_store;
            addr_o  <= {addr[31:2], 2'b00};
            be_o    <= be_calc;
            wdata_o <= wdata_calc;
            op_q    <= mem_op;
            lane_q  <= addr[1:0];
          end
        end
        // Bus fields stay frozen until the grant; only req_o drops after it.
        S_REQ:  if (gnt_i)    req_o   <= 1'b0;
        S_WAIT: if (rvalid_i) rdata_o <= load_ext(op_q, lane_q, rdata_i);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_m_lsu.sv
// ---------------------------------------------------------------------------
// tb_m_lsu -- self-checking bench for m_lsu.
//
// Directed accesses are driven one at a time. For each one the bench works
// out, from the access rules (operand size, lane arithmetic, extension), what
// every output must be on each cycle and publishes it in exp_*; a single
// compare process checks the DUT against exp_* on every falling edge.
// Literal expectations after selected accesses pin the model itself.
// ---------------------------------------------------------------------------
module tb_m_lsu;

  localparam logic [3:0] OP_NONE = 4'd0;
  localparam logic [3:0] OP_LW   = 4'd1;
  localparam logic [3:0] OP_LH   = 4'd2;
  localparam logic [3:0] OP_LHU  = 4'd3;
  localparam logic [3:0] OP_LB   = 4'd4;
  localparam logic [3:0] OP_LBU  = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_SH   = 4'd7;
  localparam logic [3:0] OP_SB   = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [3:0]  mem_op;
  logic [31:0] addr;
  logic        ov_dm;
  logic [31:0] wdata;
  logic        req_o;
  logic        we_o;
  logic [31:0] addr_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic        gnt_i;
  logic        rvalid_i;
  logic [31:0] rdata_i;
  logic        stall;
  logic        done;
  logic [31:0] rdata_o;
  logic        exc_valid;
  logic [4:0]  exc_code;

  m_lsu dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .mem_op    (mem_op),
    .addr      (addr),
    .ov_dm     (ov_dm),
    .wdata     (wdata),
    .req_o     (req_o),
    .we_o      (we_o),
    .addr_o    (addr_o),
    .be_o      (be_o),
    .wdata_o   (wdata_o),
    .gnt_i     (gnt_i),
    .rvalid_i  (rvalid_i),
    .rdata_i   (rdata_i),
    .stall     (stall),
    .done      (done),
    .rdata_o   (rdata_o),
    .exc_valid (exc_valid),
    .exc_code  (exc_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp,
               $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Expected outputs for the current cycle, published by the driver.
  // ---------------------------------------------------------------------
  logic        exp_en     = 1'b0;
  logic        exp_stall  = 1'b0;
  logic        exp_req    = 1'b0;
  logic        exp_we     = 1'b0;
  logic [31:0] exp_addr   = '0;
  logic [3:0]  exp_be     = '0;
  logic [31:0] exp_wd     = '0;
  logic        exp_done   = 1'b0;
  logic        exp_rd_en  = 1'b0;
  logic [31:0] exp_rdata  = '0;
  logic        exp_exc    = 1'b0;
  logic [4:0]  exp_code   = '0;

  // Observation counters, written only by the compare process.
  int          n_req_cyc   = 0;
  int          n_stall_cyc = 0;
  int          n_done_cyc  = 0;
  logic [31:0] last_addr   = '0;
  logic [3:0]  last_be     = '0;
  logic [31:0] last_wd     = '0;
  logic        last_we     = 1'b0;
  logic [31:0] last_rdata  = '0;
  logic [4:0]  last_code   = '0;

  always @(negedge clk) begin
    if (exp_en) begin
      check("stall", {31'd0, stall}, {31'd0, exp_stall});
      check("req_o", {31'd0, req_o}, {31'd0, exp_req});
      if (exp_req) begin
        check("we_o", {31'd0, we_o}, {31'd0, exp_we});
        check("addr_o", addr_o, exp_addr);
        check("be_o", {28'd0, be_o}, {28'd0, exp_be});
        if (exp_we) check("wdata_o", wdata_o, exp_wd);
      end
      check("done", {31'd0, done}, {31'd0, exp_done});
      check("exc_valid", {31'd0, exc_valid}, {31'd0, exp_exc});
      check("exc_code", {27'd0, exc_code}, {27'd0, exp_code});
      check("exc_done_excl", {31'd0, exc_valid & done}, 32'd0);
      if (exp_done && exp_rd_en) check("rdata_o", rdata_o, exp_rdata);
    end
    if (req_o) begin
      n_req_cyc++;
      last_addr = addr_o;
      last_be   = be_o;
      last_wd   = wdata_o;
      last_we   = we_o;
    end
    if (stall) n_stall_cyc++;
    if (done) begin
      n_done_cyc++;
      last_rdata = rdata_o;
    end
    if (exc_valid) last_code = exc_code;
  end

  // ---------------------------------------------------------------------
  // Reference model: derived from operand size and lane arithmetic.
  // ---------------------------------------------------------------------
  function automatic int op_size(input logic [3:0] op);
    case (op)
      OP_LW, OP_SW:         return 4;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LB, OP_LBU, OP_SB: return 1;
      default:              return 0;
    endcase
  endfunction

  function automatic logic [3:0] model_be(input logic [3:0] op,
                                          input logic [31:0] a);
    int sz  = op_size(op);
    int off = int'(a % 4);
    logic [3:0] mask;
    mask = 4'((1 << sz) - 1);
    return mask << ((off / sz) * sz);
  endfunction

  function automatic logic [31:0] model_wd(input logic [3:0] op,
                                           input logic [31:0] wd);
    int sz = op_size(op);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % sz) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] model_load(input logic [3:0] op,
                                             input logic [31:0] a,
                                             input logic [31:0] raw);
    int sz = op_size(op);
    longint unsigned v;
    longint unsigned lim;
    if (sz == 4) return raw;
    v   = (longint'(raw) >> (8 * int'(a % 4) / sz * sz)) & ((64'd1 << (8*sz)) - 1);
    lim = 64'd1 << (8*sz - 1);
    if ((op == OP_LB || op == OP_LH) && v >= lim) v = v + 64'hFFFF_FFFF - (2*lim - 1);
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_exp();
    exp_stall = 1'b0; exp_req  = 1'b0; exp_we   = 1'b0; exp_done = 1'b0;
    exp_rd_en = 1'b0; exp_exc  = 1'b0; exp_code = 5'd0;
  endtask

  // One instruction in M: gd = REQ cycles before the grant, rd = cycles
  // from the grant to rvalid (loads, >= 1). Junk is driven on gnt_i/rvalid_i
  // in states that must ignore them.
  task automatic do_access(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] wd, input logic ov,
                           input int gd, input int rd,
                           input logic [31:0] raw);
    int  sz    = op_size(op);
    bit  st    = (op == OP_SW || op == OP_SH || op == OP_SB);
    bit  flt;
    valid_in = 1'b1; mem_op = op; addr = a; ov_dm = ov; wdata = wd;
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h5555_AAAA;
    clear_exp();
    exp_en = 1'b1;
    if (sz == 0) begin
      step();
      valid_in = 1'b0;
      return;
    end
    flt = ov || ((a % sz) != 0);
    if (flt) begin
      exp_exc  = 1'b1;
      exp_code = st ? 5'd5 : 5'd4;
      step();
      valid_in = 1'b0;
      clear_exp();
      step();
      return;
    end
    exp_stall = 1'b1;
    step();
    exp_req  = 1'b1;
    exp_we   = st;
    exp_addr = a & 32'hFFFF_FFFC;
    exp_be   = model_be(op, a);
    exp_wd   = model_wd(op, wd);
    for (int k = 0; k <= gd; k++) begin
      gnt_i    = (k == gd);
      rvalid_i = (k != gd);
      rdata_i  = 32'hBAD0_0000 | k;
      step();
    end
    gnt_i = 1'b0; rvalid_i = 1'b0; exp_req = 1'b0;
    if (!st) begin
      for (int j = 1; j <= rd; j++) begin
        rvalid_i = (j == rd);
        gnt_i    = (j != rd);
        rdata_i  = (j == rd) ? raw : (32'hC0DE_0000 | j);
        step();
      end
    end
    gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = 32'h0;
    exp_stall = 1'b0;
    exp_done  = 1'b1;
    exp_rd_en = !st;
    exp_rdata = model_load(op, a, raw);
    step();
    valid_in = 1'b0;
    clear_exp();
    step();
  endtask

  int req0, stall0, done0;

  task automatic mark();
    req0 = n_req_cyc; stall0 = n_stall_cyc; done0 = n_done_cyc;
  endtask

  initial begin
    reset = 1'b0; valid_in = 1'b0; mem_op = OP_NONE; addr = '0; ov_dm = 1'b0;
    wdata = '0; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    #1;
    check("rst_req", {31'd0, req_o}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_rdata", rdata_o, 32'd0);
    @(negedge clk); #1 reset = 1'b1;
    step();

    // SW, grant on first REQ cycle.
    mark();
    do_access(OP_SW, 32'h0000_1008, 32'hDEAD_BEEF, 1'b0, 0, 0, 32'h0);
    check("sw_req_cycles", n_req_cyc - req0, 32'd1);
    check("sw_stall_cycles", n_stall_cyc - stall0, 32'd2);
    check("sw_done_cycles", n_done_cyc - done0, 32'd1);
    check("sw_addr", last_addr, 32'h0000_1008);
    check("sw_be", {28'd0, last_be}, 32'h0000_000F);
    check("sw_we", {31'd0, last_we}, 32'd1);
    check("sw_wd", last_wd, 32'hDEAD_BEEF);

    do_access(OP_SB, 32'h0000_1003, 32'h0000_00A5, 1'b0, 0, 0, 32'h0);
    check("sb_be", {28'd0, last_be}, 32'h0000_0008);
    check("sb_wd", last_wd, 32'hA5A5_A5A5);
    do_access(OP_SH, 32'h0000_1002, 32'h1234_ABCD, 1'b0, 1, 0, 32'h0);
    check("sh_be", {28'd0, last_be}, 32'h0000_000C);
    check("sh_wd", last_wd, 32'hABCD_ABCD);

    // Loads.
    mark();
    do_access(OP_LB, 32'h0000_2001, 32'h0, 1'b0, 3, 2, 32'h1234_80FF);
    check("lb_req_cycles", n_req_cyc - req0, 32'd4);
    check("lb_rdata", last_rdata, 32'hFFFF_FF80);
    do_access(OP_LBU, 32'h0000_2001, 32'h0, 1'b0, 3, 2, 32'h1234_80FF);
    check("lbu_rdata", last_rdata, 32'h0000_0080);
    do_access(OP_LH, 32'h0000_2002, 32'h0, 1'b0, 0, 1, 32'h8001_7FFF);
    check("lh_rdata", last_rdata, 32'hFFFF_8001);
    do_access(OP_LHU, 32'h0000_2000, 32'h0, 1'b0, 2, 3, 32'h8001_FFFE);
    check("lhu_rdata", last_rdata, 32'h0000_FFFE);
    mark();
    do_access(OP_LW, 32'h0000_2004, 32'h0, 1'b0, 0, 1, 32'h89AB_CDEF);
    check("lw_rdata", last_rdata, 32'h89AB_CDEF);
    check("lw_stall_cycles", n_stall_cyc - stall0, 32'd3);
    do_access(OP_LB, 32'h0000_2003, 32'h0, 1'b0, 0, 1, 32'h7F00_0000);

    // Non-accesses.
    do_access(OP_NONE, 32'h0000_3002, 32'h0, 1'b1, 0, 0, 32'h0);
    do_access(4'hF, 32'h0000_3001, 32'h0, 1'b0, 0, 0, 32'h0);

    // Faults.
    mark();
    do_access(OP_LW, 32'h0000_3002, 32'h0, 1'b0, 0, 0, 32'h0);
    check("adel_code", {27'd0, last_code}, 32'd4);
    check("adel_no_req", n_req_cyc - req0, 32'd0);
    check("adel_no_stall", n_stall_cyc - stall0, 32'd0);
    do_access(OP_SH, 32'h0000_3001, 32'h0, 1'b0, 0, 0, 32'h0);
    check("ades_sh_code", {27'd0, last_code}, 32'd5);
    do_access(OP_SW, 32'h0000_3000, 32'h0, 1'b1, 0, 0, 32'h0);
    check("ades_ov_code", {27'd0, last_code}, 32'd5);
    do_access(OP_LB, 32'h0000_3000, 32'h0, 1'b1, 0, 0, 32'h0);
    check("adel_ov_code", {27'd0, last_code}, 32'd4);

    // Reset while waiting for load data.
    exp_en = 1'b0;
    valid_in = 1'b1; mem_op = OP_LW; addr = 32'h0000_4000; ov_dm = 1'b0;
    step();
    gnt_i = 1'b1;
    step();
    gnt_i = 1'b0;
    valid_in = 1'b0;
    step();
    check("wait_stall", {31'd0, stall}, 32'd1);
    #2 reset = 1'b0;
    #1;
    check("arst_req", {31'd0, req_o}, 32'd0);
    check("arst_we", {31'd0, we_o}, 32'd0);
    check("arst_addr", addr_o, 32'd0);
    check("arst_be", {28'd0, be_o}, 32'd0);
    check("arst_stall", {31'd0, stall}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    check("arst_exc", {31'd0, exc_valid}, 32'd0);
    @(negedge clk); #1 reset = 1'b1;
    mark();
    clear_exp();
    exp_en = 1'b1;
    rvalid_i = 1'b1; rdata_i = 32'hFEED_FACE;
    step();
    rvalid_i = 1'b0;
    step();
    check("late_rvalid_rdata", rdata_o, 32'd0);
    check("late_rvalid_no_done", n_done_cyc - done0, 32'd0);
    mark();
    do_access(OP_SW, 32'h0000_500C, 32'h0BAD_F00D, 1'b0, 0, 0, 32'h0);
    check("post_rst_sw_done", n_done_cyc - done0, 32'd1);
    check("post_rst_sw_addr", last_addr, 32'h0000_500C);

    exp_en = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
